rom_burst_reader: RTL and testbench
===================================

# rom_burst_reader

Sequencer that sits directly downstream of the 64×16 tag/key ROM. On a start command it issues a burst of consecutive ROM reads from a start address, absorbing the ROM's one-cycle read latency. The words are presented to the consumer (crypto core key loader, EPC/TID reply path) as a valid/ready stream, and the block applies backpressure by gating the ROM chip enable.

## Interface
- `FIFO_DEPTH`, default 2: output buffer depth; 2 is the minimum for full throughput.
- `CLK` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: burst request, sampled only when `busy`=0.
- `start_addr` in 6: first ROM word address.
- `word_cnt` in 7: number of words. 0 means an empty burst; values above 64 saturate to 64.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle `done` pulses.
- `done` out 1: one-cycle pulse when the burst is complete.
- `rom_cen` out 1: ROM chip enable, active-low.
- `rom_a` out 6: ROM address.
- `rom_q` in 16: ROM data, valid the cycle after `rom_cen`=0.
- `dout` out 16: stream data.
- `dout_valid` out 1: stream valid.
- `dout_ready` in 1: stream ready. A transfer occurs when valid and ready are both high.

## Operation
- Reset values: `busy`=0, `done`=0, `rom_cen`=1, `rom_a`=0, `dout`=0, `dout_valid`=0. Reset also flushes the FIFO and clears the in-flight flag and all counters.
- A reset mid-burst abandons the burst immediately; no `done` pulse is produced.
- States:
  - IDLE: `start` with `word_cnt`≠0 latches `addr`=`start_addr`, `issue_left`=`word_cnt` (saturated) and `pop_left`=`word_cnt` (saturated), then goes to READ. `start` with `word_cnt`=0 goes to DONE.
  - READ: issues reads until `issue_left`=0, then goes to DRAIN.
  - DRAIN: waits until `pop_left`=0, then goes to DONE.
  - DONE: one cycle, `done`=1, `busy`=0, then back to IDLE.
- Read issue:
  - `rom_cen`=0 and `rom_a`=`addr` in a READ cycle when `issue_left`>0 and a slot exists.
  - A slot exists when occupancy + inflight < `FIFO_DEPTH`, or when it equals `FIFO_DEPTH` and a pop occurs this cycle.
  - On issue: `addr` increments modulo 64 (63 wraps to 0), `issue_left` decrements, and `inflight` is set for the next cycle.
- Capture: in the cycle after an issue, `rom_q` is pushed into the FIFO. `rom_q` is never sampled in any other cycle, because the ROM holds Q while CEN is high.
- Output: `dout`/`dout_valid` come from the FIFO head. Each pop decrements `pop_left`.
- `dout` holds its value while `dout_valid`=1 and `dout_ready`=0.
- A push and a pop in the same cycle are both allowed. The FIFO never overflows; the credit rule above is what guarantees this.
- `start` is ignored while `busy`=1 or in the DONE cycle.
- `rom_cen` is 1 in every state other than READ.

## Timing
- `start` in cycle 0 gives `busy`=1, `rom_cen`=0 and `rom_a`=`start_addr` in cycle 1.
- The ROM registers its data at the end of cycle 1. The FIFO push happens at the end of cycle 2. `dout_valid`=1 in cycle 3. The latency from start to first valid is 3 cycles.
- With `dout_ready` held high, throughput is 1 word/cycle: N words occupy cycles 3 through N+2.
- `done` pulses in the cycle after the last pop.
- An empty burst (`start` with `word_cnt`=0 in cycle 0) produces `done` in cycle 1 with no ROM access.
- When `dout_ready` drops, issue stops within 1 cycle. At most `FIFO_DEPTH` words are buffered.

## Structure
- Shared package `ecc_rom_pkg`:
  - `ROM_AW`=6, `ROM_DW`=16, `ROM_DEPTH`=64.
  - Map constants: `EPC_BASE`=0, `TID_BASE`=16, `USER_BASE`=32, `KEY_BASE`=48, `KEY_WORDS`=8.
  - The `rd_state_t` enum (IDLE/READ/DRAIN/DONE).
- Sub-module `rom_rd_fifo`: synchronous FIFO with parameterized depth, push/pop/count/empty outputs and a registered head. Everything else stays in the top.

## Test plan
- Key load: `start_addr`=48, `word_cnt`=8, `dout_ready`=1 → `dout` is 0x2b7e, 0x1516, 0x28ae, 0xd2a6, 0xabf7, 0x1588, 0x09cf, 0x4f3c in cycles 3–10; `done` in cycle 11; exactly 8 cycles with `rom_cen`=0.
- Wrap: `start_addr`=62, `word_cnt`=4 → 0xb663, 0x0ca6, 0xdcdc, 0x34b2; `rom_a` sequence 62, 63, 0, 1.
- Backpressure: `start_addr`=16, `word_cnt`=5, `dout_ready` toggling with random stalls → stream 0x78f6, 0x1800, 0x1111, 0x2222, 0x3333, in order, with no loss or duplication; FIFO occupancy never exceeds 2; `dout` is stable during stalls.
- Edge counts:
  - `word_cnt`=0 → `done` in cycle 1 and no `rom_cen` low.
  - `word_cnt`=100 at `start_addr`=0 → exactly 64 words, ending with 0x0ca6.
- Ignored start and reset:
  - Second `start` while `busy` → ignored.
  - `rst` asserted in cycle 5 of a 16-word burst → outputs return to their reset values in the next cycle; no `done`.
  - A new burst issued afterwards produces correct data.

Source files
------------

// File: rtl/ecc_rom_pkg.sv
// Shared constants and types for the 64x16 tag/key ROM and its burst reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecc_rom_pkg;

  localparam int ROM_AW    = 6;
  localparam int ROM_DW    = 16;
  localparam int ROM_DEPTH = 64;

  // ROM map: EPC, TID, user memory and the crypto key each own a 16-word region
  localparam int EPC_BASE  = 0;
  localparam int TID_BASE  = 16;
  localparam int USER_BASE = 32;
  localparam int KEY_BASE  = 48;
  localparam int KEY_WORDS = 8;

  // Width of the word counters; holds 0..64 inclusive
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  // A burst never covers more than the whole ROM
  function automatic logic [CNT_W-1:0] sat_word_cnt(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(ROM_DEPTH)) ? CNT_W'(ROM_DEPTH) : n;
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Small shift-style FIFO whose head word lives in a flop (mem_q[0]).
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the writer guarantees it never pushes into a full FIFO without a pop.
module rom_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                din,
  input  logic                         pop,
  output logic [DW-1:0]                head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] wr_idx;
  logic          pop_ok;

  assign pop_ok = pop && (count_q != '0);

  // Shift out on pop, then write the new word just behind the last valid entry
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    wr_idx  = count_q;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_idx = count_q - CW'(1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (int'(wr_idx) == i)) begin
        mem_d[i] = din;
      end
    end
    count_d = count_q + CW'(push) - CW'(pop_ok);
  end

  // Storage and occupancy registers; reset flushes contents to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/rom_burst_reader.sv
// Issues a burst of consecutive ROM reads and streams the words out as valid/ready.
// Latency: start to first dout_valid is 3 cycles; 1 word/cycle with dout_ready held high.
// Backpressure: ROM chip enable is gated by a credit check so at most FIFO_DEPTH words are ever outstanding.
module rom_burst_reader
  import ecc_rom_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [ROM_AW-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              done,
  output logic              rom_cen,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [ROM_DW-1:0] rom_q,
  output logic [ROM_DW-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  rd_state_t         state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  issue_left_q, issue_left_d;
  logic [CNT_W-1:0]  pop_left_q, pop_left_d;
  logic              inflight_q, inflight_d;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              pop;
  logic              slot;
  logic              issue;
  logic              accept;

  // Words already owed to the FIFO (buffered + one in the ROM pipeline) must leave room for one more
  assign pop    = dout_valid && dout_ready;
  assign slot   = ((int'(fifo_cnt) + int'(inflight_q)) < FIFO_DEPTH) || pop;
  assign issue  = (state_q == READ) && (issue_left_q != '0) && slot;
  assign accept = (state_q == IDLE) && start;

  rom_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (ROM_DW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .push  (inflight_q),
    .din   (rom_q),
    .pop   (pop),
    .head  (dout),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign dout_valid = !fifo_empty;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; DRAIN leaves on the cycle of the last pop so done follows it directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (word_cnt == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue_left_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((pop_left_q == '0) || ((pop_left_q == CNT_W'(1)) && pop)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs; ROM is only enabled for an issuing READ cycle
  always_comb begin
    busy    = (state_q == READ) || (state_q == DRAIN);
    done    = (state_q == DONE);
    rom_cen = !issue;
    rom_a   = addr_q;
  end

  // Burst address and counters: load on accept, step on issue and pop
  always_comb begin
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    inflight_d   = issue;
    if (accept && (word_cnt != '0)) begin
      addr_d       = start_addr;
      issue_left_d = sat_word_cnt(word_cnt);
      pop_left_d   = sat_word_cnt(word_cnt);
    end
    if (issue) begin
      addr_d       = addr_q + ROM_AW'(1);
      issue_left_d = issue_left_q - CNT_W'(1);
    end
    if (pop && (pop_left_q != '0)) begin
      pop_left_d = pop_left_q - CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: ROM model, random backpressure, per-cycle scoreboard plus literal pins.
// Latency: n/a.
// Backpressure: dout_ready driven always-high or random per scenario.
module tb_rom_burst_reader;

  localparam int DEPTH    = 2;
  localparam int PH_IDLE  = 0;
  localparam int PH_ACT   = 1;
  localparam int PH_DONE  = 2;

  logic        CLK = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  word_cnt;
  logic        busy, done, rom_cen;
  logic [5:0]  rom_a;
  logic [15:0] rom_q = 16'h0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ready_mode = 0;

  logic [15:0] rom_mem [64];

  // Scoreboard model state
  int          m_phase, m_issue_left, m_pop_left, m_next_addr;
  logic [15:0] m_data_q [$];
  int          m_icyc_q [$];
  logic        prev_stall;
  logic [15:0] prev_dout;

  // Observation logs for literal checks
  int          pop_cyc [$];
  logic [15:0] pop_dat [$];
  int          rom_a_log [$];
  int          cen_low;
  int          done_cyc;
  int          done_cnt;

  rom_burst_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .word_cnt   (word_cnt),
    .busy       (busy),
    .done       (done),
    .rom_cen    (rom_cen),
    .rom_a      (rom_a),
    .rom_q      (rom_q),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ROM: one-cycle read latency, Q held while CEN is high
  always @(posedge CLK) if (rom_cen === 1'b0) rom_q <= rom_mem[rom_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle scoreboard: what the stream and ROM port must look like from the burst rules
  always @(negedge CLK) begin : model_cmp
    bit exp_valid;
    bit pop_now;
    bit exp_issue;
    int n;
    if (rst) begin
      m_phase      = PH_IDLE;
      m_issue_left = 0;
      m_pop_left   = 0;
      m_next_addr  = 0;
      m_data_q.delete();
      m_icyc_q.delete();
      prev_stall   = 1'b0;
    end else begin
      exp_valid = (m_icyc_q.size() > 0) && (m_icyc_q[0] <= cyc - 2);
      pop_now   = exp_valid && (dout_ready == 1'b1);
      exp_issue = (m_phase == PH_ACT) && (m_issue_left > 0) &&
                  ((m_data_q.size() < DEPTH) || pop_now);

      chk("busy", 32'(busy), 32'(m_phase == PH_ACT));
      chk("done", 32'(done), 32'(m_phase == PH_DONE));
      chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
      if (exp_valid) chk("dout", 32'(dout), 32'(m_data_q[0]));
      if (prev_stall) chk("stall_hold", 32'(dout), 32'(prev_dout));
      chk("rom_cen", 32'(rom_cen), 32'(!exp_issue));

      if (pop_now) begin
        pop_cyc.push_back(cyc);
        pop_dat.push_back(dout);
        void'(m_data_q.pop_front());
        void'(m_icyc_q.pop_front());
        m_pop_left--;
      end
      if (exp_issue) begin
        chk("rom_a", 32'(rom_a), 32'(m_next_addr));
        rom_a_log.push_back(int'(rom_a));
        m_data_q.push_back(rom_mem[m_next_addr]);
        m_icyc_q.push_back(cyc);
        m_next_addr = (m_next_addr + 1) % 64;
        m_issue_left--;
      end
      if (rom_cen === 1'b0) cen_low++;
      chk("occupancy", 32'(m_data_q.size() <= DEPTH), 32'd1);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end

      case (m_phase)
        PH_IDLE: begin
          if (start) begin
            n = (word_cnt > 7'd64) ? 64 : int'(word_cnt);
            if (n == 0) begin
              m_phase = PH_DONE;
            end else begin
              m_phase      = PH_ACT;
              m_issue_left = n;
              m_pop_left   = n;
              m_next_addr  = int'(start_addr);
            end
          end
        end
        PH_ACT: if (pop_now && (m_pop_left == 0)) m_phase = PH_DONE;
        default: m_phase = PH_IDLE;
      endcase

      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  // Consumer: always ready or random stalls
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      dout_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic clear_logs();
    pop_cyc.delete();
    pop_dat.delete();
    rom_a_log.delete();
    cen_low  = 0;
    done_cyc = -1;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input int sa, input int wc, output int t0);
    @(posedge CLK);
    #1;
    start      = 1'b1;
    start_addr = 6'(sa);
    word_cnt   = 7'(wc);
    t0         = cyc;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((done_cnt == 0) && (n < budget)) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    32'(busy),       32'd0);
    chk({tag, "_done"},    32'(done),       32'd0);
    chk({tag, "_rom_cen"}, 32'(rom_cen),    32'd1);
    chk({tag, "_rom_a"},   32'(rom_a),      32'd0);
    chk({tag, "_dout"},    32'(dout),       32'd0);
    chk({tag, "_valid"},   32'(dout_valid), 32'd0);
  endtask

  logic [15:0] key_exp  [8] = '{16'h2b7e, 16'h1516, 16'h28ae, 16'hd2a6,
                                16'habf7, 16'h1588, 16'h09cf, 16'h4f3c};
  logic [15:0] wrap_exp [4] = '{16'hb663, 16'h0ca6, 16'hdcdc, 16'h34b2};
  int          wrap_a   [4] = '{62, 63, 0, 1};
  logic [15:0] bp_exp   [5] = '{16'h78f6, 16'h1800, 16'h1111, 16'h2222, 16'h3333};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int sa, wc, n;
    for (int i = 0; i < 64; i++) rom_mem[i] = 16'(i * 16'h0123 + 16'h0400);
    rom_mem[0]  = 16'hdcdc; rom_mem[1]  = 16'h34b2;
    rom_mem[16] = 16'h78f6; rom_mem[17] = 16'h1800; rom_mem[18] = 16'h1111;
    rom_mem[19] = 16'h2222; rom_mem[20] = 16'h3333;
    for (int i = 0; i < 8; i++) rom_mem[48 + i] = key_exp[i];
    rom_mem[62] = 16'hb663; rom_mem[63] = 16'h0ca6;

    rst = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0;
    clear_logs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    @(posedge CLK);
    #1;
    rst = 1'b0;

    // Key load with full throughput
    clear_logs();
    pulse_start(48, 8, t0);
    wait_done(50);
    chk("key_count", 32'(pop_dat.size()), 32'd8);
    for (int i = 0; i < 8 && i < pop_dat.size(); i++) begin
      chk("key_data", 32'(pop_dat[i]), 32'(key_exp[i]));
      chk("key_cycle", 32'(pop_cyc[i] - t0), 32'(3 + i));
    end
    chk("key_done_cycle", 32'(done_cyc - t0), 32'd11);
    chk("key_cen_low", 32'(cen_low), 32'd8);

    // Address wrap
    clear_logs();
    pulse_start(62, 4, t0);
    wait_done(50);
    chk("wrap_count", 32'(pop_dat.size()), 32'd4);
    for (int i = 0; i < 4 && i < pop_dat.size(); i++) chk("wrap_data", 32'(pop_dat[i]), 32'(wrap_exp[i]));
    for (int i = 0; i < 4 && i < rom_a_log.size(); i++) chk("wrap_rom_a", 32'(rom_a_log[i]), 32'(wrap_a[i]));

    // Random backpressure
    ready_mode = 1;
    clear_logs();
    pulse_start(16, 5, t0);
    wait_done(300);
    chk("bp_count", 32'(pop_dat.size()), 32'd5);
    for (int i = 0; i < 5 && i < pop_dat.size(); i++) chk("bp_data", 32'(pop_dat[i]), 32'(bp_exp[i]));
    ready_mode = 0;

    // Empty burst
    clear_logs();
    pulse_start(5, 0, t0);
    wait_done(10);
    chk("empty_done_cycle", 32'(done_cyc - t0), 32'd1);
    chk("empty_cen_low", 32'(cen_low), 32'd0);

    // Saturated count
    clear_logs();
    pulse_start(0, 100, t0);
    wait_done(200);
    chk("sat_count", 32'(pop_dat.size()), 32'd64);
    if (pop_dat.size() > 0) chk("sat_last", 32'(pop_dat[pop_dat.size()-1]), 32'h0ca6);

    // Second start while busy is ignored
    clear_logs();
    pulse_start(48, 8, t0);
    pulse_start(0, 3, n);
    wait_done(50);
    repeat (6) @(negedge CLK);
    chk("ign_count", 32'(pop_dat.size()), 32'd8);
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);

    // Reset in cycle 5 of a 16-word burst
    clear_logs();
    pulse_start(0, 16, t0);
    while (cyc < t0 + 5) begin
      @(posedge CLK);
      #1;
    end
    rst = 1'b1;
    @(posedge CLK);
    #1;
    rst = 1'b0;
    @(negedge CLK);
    chk_reset_outputs("midrst");
    repeat (12) @(negedge CLK);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    // Fresh burst after the reset
    clear_logs();
    pulse_start(48, 8, t0);
    wait_done(50);
    chk("post_rst_count", 32'(pop_dat.size()), 32'd8);
    if (pop_dat.size() > 0) chk("post_rst_first", 32'(pop_dat[0]), 32'h2b7e);

    // Random bursts under random backpressure
    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      sa = $urandom_range(0, 63);
      wc = $urandom_range(0, 70);
      n  = (wc > 64) ? 64 : wc;
      clear_logs();
      pulse_start(sa, wc, t0);
      wait_done(600);
      chk("rand_count", 32'(pop_dat.size()), 32'(n));
    end
    ready_mode = 0;

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
